// File: rtl/gsensor_pkg.sv
// Shared constants for the ADXL345 SPI reader: register map, the configuration
// table written after power-up, frame geometry and the sequencer state encoding.
package gsensor_pkg;

   localparam logic [5:0] REG_THRESH_ACT    = 6'h24;
   localparam logic [5:0] REG_ACT_INACT_CTL = 6'h27;
   localparam logic [5:0] REG_BW_RATE       = 6'h2C;
   localparam logic [5:0] REG_POWER_CTL     = 6'h2D;
   localparam logic [5:0] REG_INT_ENABLE    = 6'h2E;
   localparam logic [5:0] REG_INT_MAP       = 6'h2F;
   localparam logic [5:0] REG_DATA_FORMAT   = 6'h31;
   localparam logic [5:0] REG_DATAX0        = 6'h32;

   // read, multi-byte, starting at DATAX0
   localparam logic [7:0] CMD_READ_X = {1'b1, 1'b1, REG_DATAX0};

   localparam logic [4:0] WR_LEN    = 5'd16;
   localparam logic [4:0] RD_LEN    = 5'd24;
   localparam logic [4:0] RD_TA_BIT = 5'd8;
   localparam logic [4:0] NO_TA_BIT = 5'd31;

   localparam logic [2:0] CFG_LAST = 3'd6;

   typedef struct packed {
      logic [5:0] addr;
      logic [7:0] data;
   } cfg_entry_t;

   // Entry 0 is the rightmost: DATA_FORMAT must go first so the sensor is in 3-wire mode.
   localparam cfg_entry_t [6:0] CFG_TABLE = {
      REG_POWER_CTL,     8'h08,
      REG_INT_MAP,       8'h10,
      REG_INT_ENABLE,    8'h10,
      REG_ACT_INACT_CTL, 8'h70,
      REG_THRESH_ACT,    8'h20,
      REG_BW_RATE,       8'h09,
      REG_DATA_FORMAT,   8'h40
   };

   typedef enum logic [2:0] {
      ST_PWRUP,
      ST_CFG,
      ST_CFG_GAP,
      ST_WAIT,
      ST_READ,
      ST_RD_DONE
   } state_t;

   function automatic logic [23:0] cfg_tx_word(input logic [2:0] idx);
      cfg_entry_t e;
      e = CFG_TABLE[idx];
      return {1'b0, 1'b0, e.addr, e.data, 8'h00};
   endfunction

endpackage

// File: rtl/gsensor_spi_reader_spi_m3_shift.sv
// Generic SPI mode-3 frame engine: MSB-first, left-justified tx word, optional
// mid-frame turnaround where the master releases SDIO to receive.
module spi_m3_shift
   import gsensor_pkg::*;
#(
   parameter int CLK_DIV = 25
) (
   input  logic        iCLK,
   input  logic        iRSTN,
   input  logic        start_i,
   input  logic [4:0]  len_i,
   input  logic [23:0] tx_i,
   input  logic [4:0]  ta_idx_i,
   input  logic        sdi_i,
   output logic        csn_o,
   output logic        sclk_o,
   output logic        sdo_o,
   output logic        oe_o,
   output logic [15:0] rx_o,
   output logic        done_o
);

   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

   logic        csn_q, csn_d, sclk_q, sclk_d, sdo_q, sdo_d, oe_q, oe_d, done_q, done_d;
   logic [15:0] rx_q, rx_d, div_q, div_d;
   logic [23:0] sh_q, sh_d;
   logic [5:0]  ph_q, ph_d;
   logic [4:0]  len_q, len_d, ta_q, ta_d;

   // ph_q counts SCLK half-periods: even->odd is a fall (bit k = ph/2), odd->even a rise.
   always_comb begin
      csn_d  = csn_q;
      sclk_d = sclk_q;
      sdo_d  = sdo_q;
      oe_d   = oe_q;
      rx_d   = rx_q;
      sh_d   = sh_q;
      div_d  = div_q;
      ph_d   = ph_q;
      len_d  = len_q;
      ta_d   = ta_q;
      done_d = 1'b0;
      if (csn_q) begin
         if (start_i) begin
            csn_d  = 1'b0;
            sclk_d = 1'b1;
            oe_d   = 1'b1;
            sdo_d  = tx_i[23];
            sh_d   = {tx_i[22:0], 1'b0};
            div_d  = 16'd0;
            ph_d   = 6'd0;
            len_d  = len_i;
            ta_d   = ta_idx_i;
         end else begin
            sclk_d = 1'b1;
            oe_d   = 1'b0;
         end
      end else if (div_q != DIV_LAST) begin
         div_d = div_q + 16'd1;
      end else begin
         div_d = 16'd0;
         ph_d  = ph_q + 6'd1;
         if (ph_q == {len_q, 1'b0}) begin
            csn_d  = 1'b1;
            sclk_d = 1'b1;
            oe_d   = 1'b0;
            sdo_d  = 1'b0;
            done_d = 1'b1;
         end else if (ph_q[0]) begin
            sclk_d = 1'b1;
            rx_d   = {rx_q[14:0], sdi_i};
         end else if (ph_q[5:1] == ta_q) begin
            sclk_d = 1'b0;
            oe_d   = 1'b0;
            sdo_d  = 1'b0;
         end else if ((ph_q != 6'd0) && oe_q) begin
            sclk_d = 1'b0;
            sdo_d  = sh_q[23];
            sh_d   = {sh_q[22:0], 1'b0};
         end else begin
            sclk_d = 1'b0;
         end
      end
   end

   always_ff @(posedge iCLK or negedge iRSTN) begin
      if (!iRSTN) begin
         csn_q  <= 1'b1;
         sclk_q <= 1'b1;
         sdo_q  <= 1'b0;
         oe_q   <= 1'b0;
         done_q <= 1'b0;
         rx_q   <= 16'd0;
         sh_q   <= 24'd0;
         div_q  <= 16'd0;
         ph_q   <= 6'd0;
         len_q  <= 5'd0;
         ta_q   <= 5'd0;
      end else begin
         csn_q  <= csn_d;
         sclk_q <= sclk_d;
         sdo_q  <= sdo_d;
         oe_q   <= oe_d;
         done_q <= done_d;
         rx_q   <= rx_d;
         sh_q   <= sh_d;
         div_q  <= div_d;
         ph_q   <= ph_d;
         len_q  <= len_d;
         ta_q   <= ta_d;
      end
   end

   assign csn_o  = csn_q;
   assign sclk_o = sclk_q;
   assign sdo_o  = sdo_q;
   assign oe_o   = oe_q;
   assign rx_o   = rx_q;
   assign done_o = done_q;

endmodule

// File: rtl/gsensor_spi_reader.sv
// ADXL345 reader: power-up wait, configuration table, then periodic DATAX0/X1
// reads presented as a 10-bit two's complement sample with a valid strobe.
module gsensor_spi_reader
   import gsensor_pkg::*;
#(
   parameter int CLK_DIV       = 25,
   parameter int READ_INTERVAL = 50000,
   parameter int PWRUP_CYCLES  = 100000
) (
   input  logic       iCLK,
   input  logic       iRSTN,
   output logic       oSPI_CSN,
   output logic       oSPI_SCLK,
   output logic       oSPI_SDIO_OUT,
   output logic       oSPI_SDIO_OE,
   input  logic       iSPI_SDIO_IN,
   output logic [9:0] oDIG,
   output logic       oDIG_VALID,
   output logic       oINIT_DONE
);

   localparam logic [31:0] PWR_LAST = 32'(PWRUP_CYCLES - 1);
   localparam logic [31:0] GAP_LAST = 32'(2 * CLK_DIV);
   localparam logic [31:0] IVL_LAST = 32'(READ_INTERVAL - 1);

   state_t      state_q, state_d;
   logic [2:0]  idx_q, idx_d;
   logic [31:0] cnt_q, cnt_d, ivl_q, ivl_d;
   logic [9:0]  dig_q, dig_d;
   logic        dig_valid_q, dig_valid_d, init_done_q, init_done_d;

   logic        start_s, done_s;
   logic [4:0]  len_s, ta_s;
   logic [23:0] tx_s;
   logic [15:0] rx_s;

   spi_m3_shift #(.CLK_DIV(CLK_DIV)) u_shift (
      .iCLK     (iCLK),
      .iRSTN    (iRSTN),
      .start_i  (start_s),
      .len_i    (len_s),
      .tx_i     (tx_s),
      .ta_idx_i (ta_s),
      .sdi_i    (iSPI_SDIO_IN),
      .csn_o    (oSPI_CSN),
      .sclk_o   (oSPI_SCLK),
      .sdo_o    (oSPI_SDIO_OUT),
      .oe_o     (oSPI_SDIO_OE),
      .rx_o     (rx_s),
      .done_o   (done_s)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      dig_d       = dig_q;
      dig_valid_d = 1'b0;
      init_done_d = init_done_q;
      start_s     = 1'b0;
      len_s       = WR_LEN;
      ta_s        = NO_TA_BIT;
      tx_s        = cfg_tx_word(idx_q);
      // Read cadence is set only by this counter, never by frame timing.
      if (init_done_q) begin
         ivl_d = (ivl_q == IVL_LAST) ? 32'd0 : ivl_q + 32'd1;
      end else begin
         ivl_d = 32'd0;
      end
      case (state_q)
         ST_PWRUP: begin
            if (cnt_q == PWR_LAST) begin
               state_d = ST_CFG;
               cnt_d   = 32'd0;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
         end
         ST_CFG: begin
            start_s = 1'b1;
            cnt_d   = 32'd0;
            state_d = ST_CFG_GAP;
         end
         ST_CFG_GAP: begin
            if (cnt_q == GAP_LAST) begin
               cnt_d = 32'd0;
               if (idx_q == CFG_LAST) begin
                  init_done_d = 1'b1;
                  state_d     = ST_WAIT;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  state_d = ST_CFG;
               end
            end else if (done_s || (cnt_q != 32'd0)) begin
               cnt_d = cnt_q + 32'd1;
            end else begin
               cnt_d = cnt_q;
            end
         end
         ST_WAIT: begin
            if (ivl_q == IVL_LAST) begin
               state_d = ST_READ;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_READ: begin
            start_s = 1'b1;
            len_s   = RD_LEN;
            ta_s    = RD_TA_BIT;
            tx_s    = {CMD_READ_X, 16'h0000};
            state_d = ST_RD_DONE;
         end
         ST_RD_DONE: begin
            if (done_s) begin
               dig_d       = {rx_s[1:0], rx_s[15:8]};
               dig_valid_d = 1'b1;
               state_d     = ST_WAIT;
            end else begin
               state_d = ST_RD_DONE;
            end
         end
         default: begin
            state_d = ST_PWRUP;
         end
      endcase
   end

   always_ff @(posedge iCLK or negedge iRSTN) begin
      if (!iRSTN) begin
         state_q     <= ST_PWRUP;
         idx_q       <= 3'd0;
         cnt_q       <= 32'd0;
         ivl_q       <= 32'd0;
         dig_q       <= 10'd0;
         dig_valid_q <= 1'b0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         ivl_q       <= ivl_d;
         dig_q       <= dig_d;
         dig_valid_q <= dig_valid_d;
         init_done_q <= init_done_d;
      end
   end

   assign oDIG       = dig_q;
   assign oDIG_VALID = dig_valid_q;
   assign oINIT_DONE = init_done_q;

endmodule

// File: tb/tb_gsensor_spi_reader.sv
// Directed bench for gsensor_spi_reader with a simple ADXL345 3-wire responder.
module tb_gsensor_spi_reader;

   localparam int T = 2;

   logic       iCLK, iRSTN, iSPI_SDIO_IN;
   logic       oSPI_CSN, oSPI_SCLK, oSPI_SDIO_OUT, oSPI_SDIO_OE;
   logic [9:0] oDIG;
   logic       oDIG_VALID, oINIT_DONE;

   gsensor_spi_reader #(.CLK_DIV(T), .READ_INTERVAL(200), .PWRUP_CYCLES(10)) dut (
      .iCLK          (iCLK),
      .iRSTN         (iRSTN),
      .oSPI_CSN      (oSPI_CSN),
      .oSPI_SCLK     (oSPI_SCLK),
      .oSPI_SDIO_OUT (oSPI_SDIO_OUT),
      .oSPI_SDIO_OE  (oSPI_SDIO_OE),
      .iSPI_SDIO_IN  (iSPI_SDIO_IN),
      .oDIG          (oDIG),
      .oDIG_VALID    (oDIG_VALID),
      .oINIT_DONE    (oINIT_DONE)
   );

   typedef struct {
      int          start_c;
      int          end_c;
      int          rises;
      logic [23:0] bits;
      int          oe_drop;
   } frame_t;

   frame_t      frames[$];
   int          v_cyc[$];
   logic [9:0]  v_val[$];
   int          cyc;
   int          checks = 0;
   int          errors = 0;
   int          rel_cyc;
   logic [15:0] resp;
   int          f_start, f_rises, f_falls, f_oe_drop;
   logic [23:0] f_bits;
   logic        in_frame, rd_frame;
   int          idle_viol, valid_wide, init_rises, init_cyc;

   initial begin
      iCLK = 1'b0;
      forever #5 iCLK = ~iCLK;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge iCLK);
         cyc++;
      end
   end

   // Bus monitor and sensor model: records each frame, drives read data on SCLK falls.
   initial begin
      logic   prev_csn, prev_sclk, prev_valid, prev_init;
      frame_t fr;
      iSPI_SDIO_IN = 1'b0;
      in_frame = 1'b0; rd_frame = 1'b0;
      f_start = 0; f_rises = 0; f_falls = 0; f_oe_drop = 0; f_bits = 24'd0;
      idle_viol = 0; valid_wide = 0; init_rises = 0; init_cyc = 0;
      prev_csn = 1'b1; prev_sclk = 1'b1; prev_valid = 1'b0; prev_init = 1'b0;
      forever begin
         @(negedge iCLK);
         if (!iRSTN) begin
            in_frame = 1'b0; rd_frame = 1'b0;
            prev_csn = 1'b1; prev_sclk = 1'b1; prev_valid = 1'b0; prev_init = 1'b0;
            iSPI_SDIO_IN = 1'b0;
         end else begin
            if (prev_csn && !oSPI_CSN) begin
               in_frame = 1'b1; rd_frame = 1'b0;
               f_start = cyc; f_rises = 0; f_falls = 0; f_oe_drop = 0; f_bits = 24'd0;
            end
            if (!oSPI_CSN && in_frame) begin
               if (!prev_sclk && oSPI_SCLK) begin
                  f_rises++;
                  f_bits = {f_bits[22:0], oSPI_SDIO_OUT};
                  if (!oSPI_SDIO_OE && f_oe_drop == 0) f_oe_drop = f_rises;
                  if (f_rises == 8) rd_frame = f_bits[7];
               end
               if (prev_sclk && !oSPI_SCLK) begin
                  if (rd_frame && f_falls >= 8 && f_falls < 24) iSPI_SDIO_IN = resp[23 - f_falls];
                  f_falls++;
               end
            end
            if (!prev_csn && oSPI_CSN && in_frame) begin
               fr.start_c = f_start; fr.end_c = cyc; fr.rises = f_rises;
               fr.bits = f_bits; fr.oe_drop = f_oe_drop;
               frames.push_back(fr);
               in_frame = 1'b0; rd_frame = 1'b0;
               iSPI_SDIO_IN = 1'b0;
            end
            if (oSPI_CSN && (oSPI_SDIO_OE || !oSPI_SCLK)) idle_viol++;
            if (oDIG_VALID) begin
               v_cyc.push_back(cyc);
               v_val.push_back(oDIG);
               if (prev_valid) valid_wide++;
            end
            if (oINIT_DONE && !prev_init) begin
               init_rises++;
               init_cyc = cyc;
            end
            prev_csn = oSPI_CSN; prev_sclk = oSPI_SCLK;
            prev_valid = oDIG_VALID; prev_init = oINIT_DONE;
         end
      end
   end

   task automatic wait_frames(input int n, input int budget);
      for (int i = 0; i < budget && frames.size() < n; i++) @(negedge iCLK);
      #1;
   endtask

   task automatic test_reset();
      logic quiet;
      iRSTN = 1'b0;
      repeat (3) @(negedge iCLK);
      #1;
      checks++; if (oSPI_CSN !== 1'b1) begin errors++; $display("FAIL reset_csn: got %b expected 1", oSPI_CSN); end
      checks++; if (oSPI_SCLK !== 1'b1) begin errors++; $display("FAIL reset_sclk: got %b expected 1", oSPI_SCLK); end
      checks++; if (oSPI_SDIO_OUT !== 1'b0) begin errors++; $display("FAIL reset_sdo: got %b expected 0", oSPI_SDIO_OUT); end
      checks++; if (oSPI_SDIO_OE !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b expected 0", oSPI_SDIO_OE); end
      checks++; if (oDIG !== 10'h000) begin errors++; $display("FAIL reset_dig: got %h expected 000", oDIG); end
      checks++; if (oDIG_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", oDIG_VALID); end
      checks++; if (oINIT_DONE !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b expected 0", oINIT_DONE); end
      @(negedge iCLK);
      iRSTN = 1'b1;
      rel_cyc = cyc;
      quiet = 1'b1;
      repeat (10) begin
         @(negedge iCLK);
         #1;
         if (oSPI_CSN !== 1'b1 || oSPI_SCLK !== 1'b1) quiet = 1'b0;
      end
      checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL pwrup_quiet: got bus activity %b expected 1 (idle)", quiet); end
   endtask

   task automatic test_first_frame();
      wait_frames(1, 200);
      checks++;
      if (frames.size() < 1) begin
         errors++; $display("FAIL first_frame_timeout: got %0d frames expected 1", frames.size());
         return;
      end
      if (frames[0].bits[15:0] !== 16'h3140) begin errors++; $display("FAIL first_frame_bits: got %h expected 3140", frames[0].bits[15:0]); end
      checks++; if (frames[0].rises != 16) begin errors++; $display("FAIL first_frame_rises: got %0d expected 16", frames[0].rises); end
      checks++; if (frames[0].end_c - frames[0].start_c != 33 * T) begin errors++; $display("FAIL first_frame_len: got %0d expected %0d", frames[0].end_c - frames[0].start_c, 33 * T); end
      checks++; if (frames[0].start_c - rel_cyc < 10) begin errors++; $display("FAIL first_frame_pwrup: got %0d expected >=10", frames[0].start_c - rel_cyc); end
   endtask

   task automatic test_init();
      logic [15:0] exp_words [7];
      exp_words = '{16'h3140, 16'h2C09, 16'h2420, 16'h2770, 16'h2E10, 16'h2F10, 16'h2D08};
      wait_frames(7, 1000);
      checks++;
      if (frames.size() < 7) begin
         errors++; $display("FAIL init_timeout: got %0d frames expected 7", frames.size());
         return;
      end
      for (int i = 0; i < 7; i++) begin
         checks++; if (frames[i].bits[15:0] !== exp_words[i]) begin errors++; $display("FAIL init_word%0d: got %h expected %h", i, frames[i].bits[15:0], exp_words[i]); end
         checks++; if (frames[i].oe_drop != 0) begin errors++; $display("FAIL init_oe%0d: got drop at rise %0d expected none", i, frames[i].oe_drop); end
         if (i > 0) begin
            checks++; if (frames[i].start_c - frames[i-1].end_c < 2 * T) begin errors++; $display("FAIL init_gap%0d: got %0d expected >=%0d", i, frames[i].start_c - frames[i-1].end_c, 2 * T); end
         end
      end
      for (int i = 0; i < 20 && oINIT_DONE !== 1'b1; i++) @(negedge iCLK);
      #1;
      checks++; if (oINIT_DONE !== 1'b1) begin errors++; $display("FAIL init_done: got %b expected 1", oINIT_DONE); end
      checks++; if (init_rises != 1) begin errors++; $display("FAIL init_done_rises: got %0d expected 1", init_rises); end
      checks++; if (init_cyc < frames[6].end_c + 2 * T) begin errors++; $display("FAIL init_done_time: got %0d expected >=%0d", init_cyc, frames[6].end_c + 2 * T); end
   endtask

   task automatic test_read();
      frame_t f;
      wait_frames(8, 400);
      checks++;
      if (frames.size() < 8) begin
         errors++; $display("FAIL read_timeout: got %0d frames expected 8", frames.size());
         return;
      end
      f = frames[7];
      if (f.bits[23:16] !== 8'hF2) begin errors++; $display("FAIL read_cmd: got %h expected f2", f.bits[23:16]); end
      checks++; if (f.rises != 24) begin errors++; $display("FAIL read_rises: got %0d expected 24", f.rises); end
      checks++; if (f.oe_drop != 9) begin errors++; $display("FAIL read_oe_drop: got rise %0d expected 9", f.oe_drop); end
      checks++; if (f.end_c - f.start_c != 49 * T) begin errors++; $display("FAIL read_len: got %0d expected %0d", f.end_c - f.start_c, 49 * T); end
      for (int i = 0; i < 10 && v_val.size() < 1; i++) @(negedge iCLK);
      #1;
      checks++;
      if (v_val.size() < 1) begin
         errors++; $display("FAIL read_valid_timeout: got %0d pulses expected 1", v_val.size());
         return;
      end
      if (v_val[0] !== 10'h2A5) begin errors++; $display("FAIL read_dig: got %h expected 2a5", v_val[0]); end
      checks++; if (v_cyc[0] != f.end_c + 1) begin errors++; $display("FAIL read_valid_time: got %0d expected %0d", v_cyc[0], f.end_c + 1); end
      checks++; if (valid_wide != 0) begin errors++; $display("FAIL read_valid_width: got %0d wide pulses expected 0", valid_wide); end
   endtask

   task automatic test_interval();
      resp = 16'h0001;
      wait_frames(9, 400);
      checks++;
      if (frames.size() < 9) begin
         errors++; $display("FAIL interval_timeout: got %0d frames expected 9", frames.size());
         return;
      end
      if (frames[8].start_c - frames[7].start_c != 200) begin errors++; $display("FAIL interval: got %0d expected 200", frames[8].start_c - frames[7].start_c); end
      for (int i = 0; i < 120 && v_val.size() < 2; i++) @(negedge iCLK);
      #1;
      checks++;
      if (v_val.size() < 2) begin
         errors++; $display("FAIL neg_valid_timeout: got %0d pulses expected 2", v_val.size());
         return;
      end
      if (v_val[1] !== 10'h100) begin errors++; $display("FAIL neg_dig: got %h expected 100", v_val[1]); end
      checks++; if (idle_viol != 0) begin errors++; $display("FAIL idle_bus: got %0d violations expected 0", idle_viol); end
   endtask

   task automatic test_reset_mid_read();
      logic hit;
      int   vcount, nf;
      hit = 1'b0;
      for (int k = 0; k < 400 && !hit; k++) begin
         @(negedge iCLK);
         #1;
         if (in_frame && rd_frame && f_rises == 12) hit = 1'b1;
      end
      checks++;
      if (!hit) begin
         errors++; $display("FAIL midread_timeout: got %b expected 1", hit);
         return;
      end
      #2;
      iRSTN = 1'b0;
      #1;
      checks++; if (oSPI_CSN !== 1'b1) begin errors++; $display("FAIL midread_csn: got %b expected 1", oSPI_CSN); end
      checks++; if (oSPI_SCLK !== 1'b1) begin errors++; $display("FAIL midread_sclk: got %b expected 1", oSPI_SCLK); end
      checks++; if (oSPI_SDIO_OE !== 1'b0) begin errors++; $display("FAIL midread_oe: got %b expected 0", oSPI_SDIO_OE); end
      checks++; if (oDIG !== 10'h000) begin errors++; $display("FAIL midread_dig: got %h expected 000", oDIG); end
      checks++; if (oINIT_DONE !== 1'b0) begin errors++; $display("FAIL midread_init_done: got %b expected 0", oINIT_DONE); end
      vcount = v_val.size();
      repeat (3) @(negedge iCLK);
      iRSTN = 1'b1;
      rel_cyc = cyc;
      nf = frames.size();
      wait_frames(nf + 1, 200);
      checks++;
      if (frames.size() < nf + 1) begin
         errors++; $display("FAIL restart_timeout: got %0d frames expected %0d", frames.size(), nf + 1);
         return;
      end
      if (frames[nf].bits[15:0] !== 16'h3140) begin errors++; $display("FAIL restart_bits: got %h expected 3140", frames[nf].bits[15:0]); end
      checks++; if (frames[nf].start_c - rel_cyc < 10) begin errors++; $display("FAIL restart_pwrup: got %0d expected >=10", frames[nf].start_c - rel_cyc); end
      checks++; if (v_val.size() != vcount) begin errors++; $display("FAIL restart_no_valid: got %0d pulses expected %0d", v_val.size(), vcount); end
      checks++; if (oDIG !== 10'h000) begin errors++; $display("FAIL restart_dig: got %h expected 000", oDIG); end
   endtask

   initial begin
      resp  = 16'hA5FE;
      iRSTN = 1'b0;
      test_reset();
      test_first_frame();
      test_init();
      test_read();
      test_interval();
      test_reset_mid_read();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
